// File: rtl/motion_sprite_line_engine.sv
// Multi-sprite scanline renderer. Walks the active descriptor slots on every
// line_start, fetches visible sprite rows from the sprite ROM and composites
// them into the back half of a ping-pong line buffer while the front half is
// scanned out with clear-on-read.
module motion_sprite_line_engine #(
    parameter int NUM_SPRITES = 4,
    parameter int SIZE_LOG2   = 3,
    parameter int SCALE_LOG2  = 1,
    parameter int PIXEL_BITS  = 2,
    parameter int COORD_WIDTH = 10,
    parameter int LINE_PIXELS = 320,
    parameter int COL_WIDTH   = 9,
    parameter int NUM_WIDTH   = 6,
    localparam int SLOT_WIDTH = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int ADDR_WIDTH = NUM_WIDTH + 2 * SIZE_LOG2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic                   line_start,
    input  logic [COORD_WIDTH-1:0] render_row,
    input  logic                   reg_we,
    input  logic [SLOT_WIDTH-1:0]  reg_slot,
    input  logic [1:0]             reg_field,
    input  logic [COORD_WIDTH-1:0] reg_wdata,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [PIXEL_BITS-1:0]  rom_pixel,
    input  logic                   disp_rd,
    input  logic [COL_WIDTH-1:0]   disp_col,
    output logic [PIXEL_BITS-1:0]  disp_pixel,
    output logic                   busy,
    output logic                   overrun
);

    localparam int SPAN_LOG2 = SIZE_LOG2 + SCALE_LOG2;
    localparam int SPAN      = 1 << SPAN_LOG2;
    localparam logic [COORD_WIDTH-1:0] SPAN_LIM   = COORD_WIDTH'(SPAN);
    localparam logic [SPAN_LOG2-1:0]   BEAT_LAST  = '1;
    localparam logic [SPAN_LOG2-1:0]   BEAT_ONE   = SPAN_LOG2'(1);
    localparam logic [SLOT_WIDTH-1:0]  SLOT_TOP   = SLOT_WIDTH'(NUM_SPRITES - 1);
    localparam logic [SLOT_WIDTH-1:0]  SLOT_ONE   = SLOT_WIDTH'(1);
    localparam logic [SLOT_WIDTH:0]    SLOT_LIM   = (SLOT_WIDTH + 1)'(NUM_SPRITES);
    localparam logic [COORD_WIDTH:0]   LINE_LIM_X = (COORD_WIDTH + 1)'(LINE_PIXELS);
    localparam logic [COL_WIDTH:0]     LINE_LIM_C = (COL_WIDTH + 1)'(LINE_PIXELS);

    typedef enum logic [1:0] {IDLE, SETUP, FETCH, DRAIN} state_t;

    // Right-edge clip for a sprite pixel position (computed one bit wider, so no wrap).
    function automatic logic x_on_line(input logic [COORD_WIDTH:0] x);
        return x < LINE_LIM_X;
    endfunction

    // Scan-out column range check.
    function automatic logic col_on_line(input logic [COL_WIDTH:0] col);
        return col < LINE_LIM_C;
    endfunction

    // Descriptor storage: shadow written by the CPU, active used by the renderer.
    logic [NUM_WIDTH-1:0]   shd_num [NUM_SPRITES];
    logic [COORD_WIDTH-1:0] shd_x   [NUM_SPRITES];
    logic [COORD_WIDTH-1:0] shd_y   [NUM_SPRITES];
    logic                   shd_en  [NUM_SPRITES];
    logic [NUM_WIDTH-1:0]   act_num [NUM_SPRITES];
    logic [COORD_WIDTH-1:0] act_x   [NUM_SPRITES];
    logic [COORD_WIDTH-1:0] act_y   [NUM_SPRITES];
    logic                   act_en  [NUM_SPRITES];

    // Line buffer banks; front_sel=0 means bank0 is scanned out.
    logic [PIXEL_BITS-1:0]  bank0 [LINE_PIXELS];
    logic [PIXEL_BITS-1:0]  bank1 [LINE_PIXELS];
    logic                   front_sel;

    // Render control and datapath.
    state_t                 state, state_nxt;
    logic [SLOT_WIDTH-1:0]  slot;
    logic                   slot_adv;
    logic [COORD_WIDTH-1:0] row_q;
    logic [COORD_WIDTH-1:0] dy_full;
    logic                   visible;
    logic [SPAN_LOG2-1:0]   dy_q;
    logic [SPAN_LOG2-1:0]   beat;
    logic [NUM_WIDTH-1:0]   cur_num;
    logic [COORD_WIDTH-1:0] cur_x;

    // Write-back stage, one cycle behind the ROM address.
    logic                   wb_vld_p1;
    logic [COORD_WIDTH:0]   wb_col_p1;
    logic                   wb_we;
    logic [COL_WIDTH-1:0]   wb_idx;
    logic                   rd_ok;
    logic [PIXEL_BITS-1:0]  front_pix;

    // Shadow writes from the CPU and the frame-start shadow-to-active copy.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int s = 0; s < NUM_SPRITES; s++) begin
                shd_num[s] <= '0;
                shd_x[s]   <= '0;
                shd_y[s]   <= '0;
                shd_en[s]  <= 1'b0;
                act_num[s] <= '0;
                act_x[s]   <= '0;
                act_y[s]   <= '0;
                act_en[s]  <= 1'b0;
            end
        end else begin
            if (frame_start) begin
                for (int s = 0; s < NUM_SPRITES; s++) begin
                    act_num[s] <= shd_num[s];
                    act_x[s]   <= shd_x[s];
                    act_y[s]   <= shd_y[s];
                    act_en[s]  <= shd_en[s];
                end
            end
            if (reg_we && ({1'b0, reg_slot} < SLOT_LIM)) begin
                case (reg_field)
                    2'd0:    shd_num[reg_slot] <= reg_wdata[NUM_WIDTH-1:0];
                    2'd1:    shd_x[reg_slot]   <= reg_wdata;
                    2'd2:    shd_y[reg_slot]   <= reg_wdata;
                    default: shd_en[reg_slot]  <= reg_wdata[0];
                endcase
            end
        end
    end

    // Visibility of the slot under inspection; dy wraps modulo 2^COORD_WIDTH.
    always_comb begin
        dy_full = row_q - act_y[slot];
        visible = act_en[slot] && (dy_full < SPAN_LIM);
    end

    // Next-state logic; line_start always restarts the walk from the top slot.
    always_comb begin
        state_nxt = state;
        slot_adv  = 1'b0;
        case (state)
            IDLE: state_nxt = IDLE;
            SETUP: begin
                if (visible) begin
                    state_nxt = FETCH;
                end else if (slot == '0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SETUP;
                    slot_adv  = 1'b1;
                end
            end
            FETCH: begin
                if (beat == BEAT_LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (slot == '0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SETUP;
                    slot_adv  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (line_start) begin
            state_nxt = SETUP;
            slot_adv  = 1'b0;
        end
    end

    // Control registers: FSM state, slot pointer, bank select, overrun flag, write-back valid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            slot      <= '0;
            front_sel <= 1'b0;
            overrun   <= 1'b0;
            wb_vld_p1 <= 1'b0;
        end else begin
            state     <= state_nxt;
            wb_vld_p1 <= (state == FETCH) && !line_start;
            if (line_start) begin
                front_sel <= ~front_sel;
                slot      <= SLOT_TOP;
                if (busy) overrun <= 1'b1;
            end else if (slot_adv) begin
                slot <= slot - SLOT_ONE;
            end
        end
    end

    // Render datapath: latch row, capture the visible slot, step the fetch beat.
    always_ff @(posedge clock) begin
        if (line_start) row_q <= render_row;
        if (state == SETUP) begin
            dy_q    <= dy_full[SPAN_LOG2-1:0];
            cur_num <= act_num[slot];
            cur_x   <= act_x[slot];
            beat    <= '0;
        end else if (state == FETCH) begin
            beat <= beat + BEAT_ONE;
        end
        // ---- stage boundary: ROM address -> write-back column ----
        wb_col_p1 <= {1'b0, cur_x} + (COORD_WIDTH + 1)'(beat);
    end

    // ROM address is only meaningful during FETCH; parked at zero otherwise.
    always_comb begin
        rom_addr = '0;
        if (state == FETCH) begin
            rom_addr = {cur_num, dy_q[SPAN_LOG2-1:SCALE_LOG2], beat[SPAN_LOG2-1:SCALE_LOG2]};
        end
    end

    // Write-back enable and scan-out read decode.
    always_comb begin
        busy      = (state != IDLE);
        wb_we     = wb_vld_p1 && !line_start && (rom_pixel != '0) && x_on_line(wb_col_p1);
        wb_idx    = wb_col_p1[COL_WIDTH-1:0];
        rd_ok     = disp_rd && col_on_line({1'b0, disp_col});
        front_pix = front_sel ? bank1[disp_col] : bank0[disp_col];
    end

    // Bank 0 write port: clear-on-read when front, sprite write-back when back.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int c = 0; c < LINE_PIXELS; c++) bank0[c] <= '0;
        end else if (!front_sel) begin
            if (rd_ok) bank0[disp_col] <= '0;
        end else if (wb_we) begin
            bank0[wb_idx] <= rom_pixel;
        end
    end

    // Bank 1 write port: clear-on-read when front, sprite write-back when back.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int c = 0; c < LINE_PIXELS; c++) bank1[c] <= '0;
        end else if (front_sel) begin
            if (rd_ok) bank1[disp_col] <= '0;
        end else if (wb_we) begin
            bank1[wb_idx] <= rom_pixel;
        end
    end

    // Registered scan-out pixel; out-of-line columns read as transparent.
    always_ff @(posedge clock) begin
        if (!reset) begin
            disp_pixel <= '0;
        end else if (disp_rd) begin
            disp_pixel <= rd_ok ? front_pix : '0;
        end
    end

endmodule
